// File: rtl/bh1750_lux_filter.sv
// BH1750 lux filter: power-of-two moving average over raw measurement words,
// fixed-point conversion to lux (raw/1.2), hysteretic dark flag and a
// stale-data watchdog. The window is seeded with the first sample so the
// first lux value is already meaningful.
module bh1750_lux_filter #(
  parameter int LOG2_DEPTH     = 3,
  parameter int LUX_MULT       = 54613,
  parameter int DARK_ON        = 50,
  parameter int DARK_OFF       = 80,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic [15:0] raw_data,
  input  logic        raw_valid,
  output logic [15:0] lux,
  output logic        lux_valid,
  output logic [15:0] avg_raw,
  output logic        dark,
  output logic        stale,
  output logic        overrun,
  output logic        primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = 16 + LOG2_DEPTH;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [31:0]           TIMEOUT  = 32'(TIMEOUT_CYCLES);

  logic [1:0]            state_r;
  logic [LOG2_DEPTH-1:0] wr_ptr_r;
  logic [LOG2_DEPTH-1:0] fill_ptr_r;
  logic [15:0]           first_r;
  logic [SUM_W-1:0]      sum_r;
  logic                  pend_r;
  logic                  overrun_r;
  logic                  primed_r;
  logic [15:0]           lux_r;
  logic                  lux_valid_r;
  logic [15:0]           avg_raw_r;
  logic                  dark_r;
  logic                  stale_r;
  logic [31:0]           wd_cnt_r;
  logic [15:0]           buf_mem_r [DEPTH];

  logic                  accept_s;
  logic                  buf_we_s;
  logic [LOG2_DEPTH-1:0] buf_addr_s;
  logic [15:0]           buf_data_s;
  logic [15:0]           oldest_s;
  logic [15:0]           avg_s;
  logic [31:0]           prod_s;
  logic [15:0]           lux_new_s;

  // A sample is only taken when the window can absorb it; PRIME drops it.
  assign accept_s  = raw_valid && ((state_r == ST_EMPTY) || (state_r == ST_RUN));
  assign oldest_s  = buf_mem_r[wr_ptr_r];
  assign avg_s     = 16'(sum_r >> LOG2_DEPTH);
  assign prod_s    = 32'(avg_s) * 32'(LUX_MULT);
  assign lux_new_s = 16'(prod_s >> 16);

  // Select the single buffer write for this cycle (seed, fill or replace).
  always_comb begin
    buf_we_s   = 1'b0;
    buf_addr_s = wr_ptr_r;
    buf_data_s = raw_data;
    case (state_r)
      ST_EMPTY: begin
        if (raw_valid) begin
          buf_we_s   = 1'b1;
          buf_addr_s = '0;
        end else begin
          buf_we_s   = 1'b0;
        end
      end
      ST_PRIME: begin
        buf_we_s   = 1'b1;
        buf_addr_s = fill_ptr_r;
        buf_data_s = first_r;
      end
      ST_RUN: begin
        if (raw_valid) begin
          buf_we_s = 1'b1;
        end else begin
          buf_we_s = 1'b0;
        end
      end
      default: begin
        buf_we_s = 1'b0;
      end
    endcase
  end

  // Window storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge system_clock) begin
    if (buf_we_s) begin
      buf_mem_r[buf_addr_s] <= buf_data_s;
    end
  end

  // Window FSM: running sum, pointers, prime fill and overrun flag.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state_r    <= ST_EMPTY;
      wr_ptr_r   <= '0;
      fill_ptr_r <= '0;
      first_r    <= 16'd0;
      sum_r      <= '0;
      pend_r     <= 1'b0;
      overrun_r  <= 1'b0;
      primed_r   <= 1'b0;
    end else begin
      pend_r <= accept_s;
      case (state_r)
        ST_EMPTY: begin
          if (raw_valid) begin
            first_r    <= raw_data;
            sum_r      <= SUM_W'(raw_data) << LOG2_DEPTH;
            fill_ptr_r <= LOG2_DEPTH'(1);
            state_r    <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (raw_valid) begin
            overrun_r <= 1'b1;
          end
          fill_ptr_r <= fill_ptr_r + LOG2_DEPTH'(1);
          if (fill_ptr_r == LAST_IDX) begin
            wr_ptr_r <= '0;
            primed_r <= 1'b1;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (raw_valid) begin
            sum_r    <= sum_r - SUM_W'(oldest_s) + SUM_W'(raw_data);
            wr_ptr_r <= wr_ptr_r + LOG2_DEPTH'(1);
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Output stage: one cycle after acceptance, publish average, lux and dark.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      lux_r       <= 16'd0;
      lux_valid_r <= 1'b0;
      avg_raw_r   <= 16'd0;
      dark_r      <= 1'b0;
    end else begin
      lux_valid_r <= pend_r;
      if (pend_r) begin
        avg_raw_r <= avg_s;
        lux_r     <= lux_new_s;
        if (lux_new_s < 16'(DARK_ON)) begin
          dark_r <= 1'b1;
        end else if (lux_new_s > 16'(DARK_OFF)) begin
          dark_r <= 1'b0;
        end
      end
    end
  end

  // Watchdog: counts idle cycles since the last accepted sample.
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      wd_cnt_r <= TIMEOUT;
      stale_r  <= 1'b1;
    end else if (accept_s) begin
      wd_cnt_r <= 32'd0;
      stale_r  <= 1'b0;
    end else if (wd_cnt_r != TIMEOUT) begin
      wd_cnt_r <= wd_cnt_r + 32'd1;
      if (wd_cnt_r + 32'd1 == TIMEOUT) begin
        stale_r <= 1'b1;
      end
    end
  end

  assign lux       = lux_r;
  assign lux_valid = lux_valid_r;
  assign avg_raw   = avg_raw_r;
  assign dark      = dark_r;
  assign stale     = stale_r;
  assign overrun   = overrun_r;
  assign primed    = primed_r;

endmodule

// File: tb/tb_bh1750_lux_filter.sv
// Directed bench for bh1750_lux_filter. A small window model predicts each
// lux_valid result into a queue; a monitor pops and compares on every pulse.
module tb_bh1750_lux_filter;

  localparam int K_EMPTY = 0;
  localparam int K_RUN   = 1;
  localparam int K_DROP  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] raw_data;
  logic        raw_valid;
  logic [15:0] lux;
  logic        lux_valid;
  logic [15:0] avg_raw;
  logic        dark;
  logic        stale;
  logic        overrun;
  logic        primed;

  typedef struct packed {
    logic [15:0] avg;
    logic [15:0] lux;
    logic        dark;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  int   m_buf [8];
  int   m_sum;
  int   m_ptr;
  logic m_dark;

  bh1750_lux_filter #(
    .LOG2_DEPTH(3), .LUX_MULT(54613), .DARK_ON(50), .DARK_OFF(80),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .system_clock(clk), .reset_n(reset_n), .raw_data(raw_data),
    .raw_valid(raw_valid), .lux(lux), .lux_valid(lux_valid),
    .avg_raw(avg_raw), .dark(dark), .stale(stale), .overrun(overrun),
    .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the published result for the current model window.
  task automatic push_exp();
    exp_t        e;
    logic [31:0] p;
    e.avg = 16'(m_sum / 8);
    p     = 32'(e.avg) * 32'd54613;
    e.lux = p[31:16];
    if (e.lux < 16'd50) m_dark = 1'b1;
    else if (e.lux > 16'd80) m_dark = 1'b0;
    e.dark = m_dark;
    sb.push_back(e);
  endtask

  // Drive one strobe (sampled on the next rising edge) and update the model.
  task automatic strobe(input logic [15:0] v, input int kind);
    if (kind == K_EMPTY) begin
      for (int i = 0; i < 8; i++) m_buf[i] = int'(v);
      m_sum = int'(v) * 8;
      m_ptr = 0;
      push_exp();
    end else if (kind == K_RUN) begin
      m_sum = m_sum - m_buf[m_ptr] + int'(v);
      m_buf[m_ptr] = int'(v);
      m_ptr = (m_ptr + 1) % 8;
      push_exp();
    end
    raw_data  = v;
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic prime(input logic [15:0] v);
    strobe(v, K_EMPTY);
    check("stale_falls", 32'(stale), 32'd0);
    repeat (6) @(negedge clk);
    check("primed_early", 32'(primed), 32'd0);
    @(negedge clk);
    check("primed_rise", 32'(primed), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_dark = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lux"}, 32'(lux), 32'd0);
    check({tag, "_lux_valid"}, 32'(lux_valid), 32'd0);
    check({tag, "_avg"}, 32'(avg_raw), 32'd0);
    check({tag, "_dark"}, 32'(dark), 32'd0);
    check({tag, "_stale"}, 32'(stale), 32'd1);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_primed"}, 32'(primed), 32'd0);
  endtask

  // Scoreboard monitor: every lux_valid pulse must match the next prediction.
  always @(negedge clk) begin
    if (lux_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_lux_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_avg", 32'(avg_raw), 32'(e.avg));
        check("sb_lux", 32'(lux), 32'(e.lux));
        check("sb_dark", 32'(dark), 32'(e.dark));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    raw_valid = 1'b0;
    raw_data  = 16'd0;
    m_dark    = 1'b0;
    m_sum     = 0;
    m_ptr     = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Prime with 600
    prime(16'd600);
    check("p600_avg", 32'(avg_raw), 32'd600);
    check("p600_lux", 32'(lux), 32'd499);
    check("p600_dark", 32'(dark), 32'd0);

    // Step response, back-to-back strobes
    strobe(16'd1400, K_RUN);
    @(negedge clk);
    check("step1_avg", 32'(avg_raw), 32'd700);
    check("step1_lux", 32'(lux), 32'd583);
    for (int i = 0; i < 7; i++) strobe(16'd1400, K_RUN);
    repeat (2) @(negedge clk);
    check("step8_avg", 32'(avg_raw), 32'd1400);
    check("step8_lux", 32'(lux), 32'd1166);

    // Watchdog
    strobe(16'd1400, K_RUN);
    repeat (99) @(negedge clk);
    check("wd_99", 32'(stale), 32'd0);
    @(negedge clk);
    check("wd_100", 32'(stale), 32'd1);
    strobe(16'd1400, K_RUN);
    repeat (99) @(negedge clk);
    check("wd_pre_coincide", 32'(stale), 32'd0);
    strobe(16'd1400, K_RUN);
    check("wd_coincide", 32'(stale), 32'd0);
    repeat (3) @(negedge clk);

    // Overrun during PRIME
    do_reset();
    strobe(16'd1000, K_EMPTY);
    @(negedge clk);
    strobe(16'd1234, K_DROP);
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (8) @(negedge clk);
    check("ovr_hold", 32'(overrun), 32'd1);
    check("ovr_avg", 32'(avg_raw), 32'd1000);
    check("ovr_primed", 32'(primed), 32'd1);
    strobe(16'd2000, K_RUN);
    repeat (2) @(negedge clk);
    check("ovr_run_avg", 32'(avg_raw), 32'd1125);
    check("ovr_run_lux", 32'(lux), 32'd937);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Hysteresis
    do_reset();
    prime(16'd48);
    check("h48_lux", 32'(lux), 32'd39);
    check("h48_dark", 32'(dark), 32'd1);
    do_reset();
    prime(16'd72);
    check("h72_lux", 32'(lux), 32'd59);
    check("h72_dark", 32'(dark), 32'd0);
    do_reset();
    prime(16'd48);
    for (int i = 0; i < 8; i++) strobe(16'd84, K_RUN);
    repeat (2) @(negedge clk);
    check("h84_lux", 32'(lux), 32'd69);
    check("h84_dark", 32'(dark), 32'd1);
    for (int i = 0; i < 8; i++) strobe(16'd120, K_RUN);
    repeat (2) @(negedge clk);
    check("h120_lux", 32'(lux), 32'd99);
    check("h120_dark", 32'(dark), 32'd0);

    // Reset in PRIME, while the first result is still in flight
    do_reset();
    raw_data  = 16'd500;
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_vals("midprime");
    repeat (10) @(negedge clk);
    check("midprime_quiet", 32'(lux_valid), 32'd0);
    check("midprime_primed", 32'(primed), 32'd0);
    prime(16'd600);
    check("reprime_avg", 32'(avg_raw), 32'd600);
    check("reprime_lux", 32'(lux), 32'd499);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
